// File: rtl/dm_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the two-master data-memory arbiter.
//   state_e : arbiter FSM states (idle, memory access cycle, acknowledge cycle)
//   M0, M1  : master index constants (M0 = CPU data port, M1 = DMA/IO)
//   other() : the opposite master index
// ---------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic other(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way winner selection for the data-memory arbiter.
// Ports:
//   req[1:0]   in  : request level of master 1 / master 0
//   last       in  : index of the master granted most recently
//   lock_valid in  : the last winner holds a valid lock and still requests
//   win        out : index of the selected master
//   valid      out : at least one master is requesting (win is meaningful)
// ---------------------------------------------------------------------------
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_valid,
    output logic       win,
    output logic       valid
);

    // A valid lock keeps the grant with the last winner. Without one, the
    // master that was not granted last is preferred; if it is idle the
    // remaining requester (the last winner) takes the grant.
    always_comb begin
        win   = last;
        valid = |req;
        if (lock_valid) begin
            win = last;
        end else if (req[other(last)]) begin
            win = other(last);
        end else begin
            win = last;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Shares a single-port data memory between the CPU data port (master 0) and
// a secondary requester (master 1). Each transfer takes one memory cycle
// (ACCESS) followed by a one-cycle acknowledge (RESP); read data is held in a
// per-master register. Round-robin fairness with a bounded lock for
// read-modify-write sequences.
// Parameters:
//   MAX_LOCK : maximum consecutive grants a locking master may hold
//   AW, DW   : address / data width
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mN_req/wr/lock/addr/wdata  : master N request interface
//   mN_ack                     : one-cycle completion pulse for master N
//   mN_rdata                   : last read data returned to master N
//   dm_cs/rd/wr/address/d_in   : registered memory strobes, address, data
//   dm_out                     : memory read data (combinational)
// ---------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_LOCK = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
)
(
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,

    output logic          dm_cs,
    output logic          dm_rd,
    output logic          dm_wr,
    output logic [AW-1:0] dm_address,
    output logic [DW-1:0] dm_d_in,
    input  logic [DW-1:0] dm_out
);

    // The lock counter counts re-grants after the first grant of a run, so
    // it only needs to reach MAX_LOCK-1.
    localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK - 1);

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic           wr_q, wr_d;
    logic           lock_q, lock_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic           dm_cs_q, dm_cs_d;
    logic           dm_rd_q, dm_rd_d;
    logic           dm_wr_q, dm_wr_d;
    logic [AW-1:0]  dm_address_q, dm_address_d;
    logic [DW-1:0]  dm_d_in_q, dm_d_in_d;

    logic           m0_ack_q, m0_ack_d;
    logic           m1_ack_q, m1_ack_d;
    logic [DW-1:0]  m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]  m1_rdata_q, m1_rdata_d;

    logic [1:0]     req_vec;
    logic           lock_valid;
    logic           pick_win;
    logic           pick_valid;
    logic           grant;

    logic           sel_wr;
    logic           sel_lock;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;

    assign req_vec = {m1_req, m0_req};

    // The lock is honoured only if the previous winner asked for it when it
    // was granted, is requesting again, and has not used up its allowance.
    assign lock_valid = lock_q && req_vec[last_q] && (lock_cnt_q < LOCK_LIMIT);

    rr_pick2 u_pick (
        .req        (req_vec),
        .last       (last_q),
        .lock_valid (lock_valid),
        .win        (pick_win),
        .valid      (pick_valid)
    );

    assign sel_wr    = (pick_win == M1) ? m1_wr    : m0_wr;
    assign sel_lock  = (pick_win == M1) ? m1_lock  : m0_lock;
    assign sel_addr  = (pick_win == M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (pick_win == M1) ? m1_wdata : m0_wdata;

    // Next-state and output logic. The memory-side registers (address and
    // write data) double as the request latch: they are loaded at grant time
    // and are only non-zero during ACCESS, so later changes on the master
    // inputs cannot disturb a transfer in flight. Strobes and acks default
    // to 0 so each is a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        wr_d         = wr_q;
        lock_d       = lock_q;
        lock_cnt_d   = lock_cnt_q;
        dm_cs_d      = 1'b0;
        dm_rd_d      = 1'b0;
        dm_wr_d      = 1'b0;
        dm_address_d = '0;
        dm_d_in_d    = '0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        grant        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant = pick_valid;
            end

            ST_ACCESS: begin
                state_d = ST_RESP;
                if (!wr_q) begin
                    if (last_q == M1) begin
                        m1_rdata_d = dm_out;
                    end else begin
                        m0_rdata_d = dm_out;
                    end
                end
                if (last_q == M1) begin
                    m1_ack_d = 1'b1;
                end else begin
                    m0_ack_d = 1'b1;
                end
            end

            ST_RESP: begin
                // A request still high from the master being acked here is
                // treated as a fresh request.
                grant = pick_valid;
                if (!pick_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant) begin
            state_d      = ST_ACCESS;
            last_d       = pick_win;
            wr_d         = sel_wr;
            lock_d       = sel_lock;
            lock_cnt_d   = lock_valid ? (lock_cnt_q + CNT_W'(1)) : '0;
            dm_cs_d      = 1'b1;
            dm_rd_d      = !sel_wr;
            dm_wr_d      = sel_wr;
            dm_address_d = sel_addr;
            dm_d_in_d    = sel_wr ? sel_wdata : '0;
        end
    end

    // State register. Reset abandons any transfer in flight and leaves
    // master 1 as the last grant so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_q       <= M1;
            wr_q         <= 1'b0;
            lock_q       <= 1'b0;
            lock_cnt_q   <= '0;
            dm_cs_q      <= 1'b0;
            dm_rd_q      <= 1'b0;
            dm_wr_q      <= 1'b0;
            dm_address_q <= '0;
            dm_d_in_q    <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            wr_q         <= wr_d;
            lock_q       <= lock_d;
            lock_cnt_q   <= lock_cnt_d;
            dm_cs_q      <= dm_cs_d;
            dm_rd_q      <= dm_rd_d;
            dm_wr_q      <= dm_wr_d;
            dm_address_q <= dm_address_d;
            dm_d_in_q    <= dm_d_in_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign dm_cs      = dm_cs_q;
    assign dm_rd      = dm_rd_q;
    assign dm_wr      = dm_wr_q;
    assign dm_address = dm_address_q;
    assign dm_d_in    = dm_d_in_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;

endmodule
